// File: rtl/sl_fifo_pkg.sv
// Shared types for the FIFO write arbiter slice.
//   WORD_W      : FIFO word width (2-bit tag + 32-bit payload)
//   fifo_tag_e  : word tag values carried in the top two bits
//   fifo_word_t : packed {tag, payload} view of one FIFO word
//   arb_state_e : arbiter lock state
package sl_fifo_pkg;

   localparam int WORD_W = 34;

   typedef enum logic [1:0] {
      TAG_CONFIG  = 2'd0,
      TAG_DATA    = 2'd1,
      TAG_STATUS  = 2'd2,
      TAG_CHANNEL = 2'd3
   } fifo_tag_e;

   typedef struct packed {
      fifo_tag_e   tag;
      logic [31:0] payload;
   } fifo_word_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/sl_fifo_wr_arbiter_if.sv
// Requester and FIFO-side bundle of the FIFO write arbiter.
//   req_valid/req_data/req_last : per-requester word offer (slice i of req_data)
//   req_ready                   : per-requester accept strobe
//   fifo_write_full             : FIFO back-pressure
//   fifo_write_data/inc         : registered word and push strobe toward the FIFO
//   grant_id/busy/timeout_err   : arbitration status
// master : requesters + FIFO (drive offers and full flag)
// slave  : the arbiter
interface sl_fifo_wr_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int WORD_W = sl_fifo_pkg::WORD_W
);

   localparam int GID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*WORD_W-1:0] req_data;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ-1:0]        req_ready;
   logic                    fifo_write_full;
   logic [WORD_W-1:0]       fifo_write_data;
   logic                    fifo_write_inc;
   logic [GID_W-1:0]        grant_id;
   logic                    busy;
   logic                    timeout_err;

   modport master (
      output req_valid, req_data, req_last, fifo_write_full,
      input  req_ready, fifo_write_data, fifo_write_inc, grant_id, busy, timeout_err
   );

   modport slave (
      input  req_valid, req_data, req_last, fifo_write_full,
      output req_ready, fifo_write_data, fifo_write_inc, grant_id, busy, timeout_err
   );

endinterface

// File: rtl/sl_rr_pick.sv
// Combinational rotating priority encoder.
//   req   : request vector
//   start : index with highest priority; priority falls off upward, wrapping
//   idx   : first set request at or after start (modulo N_REQ)
//   hit   : any request set
module sl_rr_pick #(
   parameter int N_REQ = 4,
   parameter int GID_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [GID_W-1:0] start,
   output logic [GID_W-1:0] idx,
   output logic             hit
);

   logic [GID_W-1:0] pos;

   always_comb begin
      idx = start;
      pos = '0;
      hit = |req;
      // Walk from the farthest candidate back toward start so the nearest set bit is written last.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         pos = GID_W'((int'(start) + i) % N_REQ);
         if (req[pos]) begin
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/sl_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ requesters.
// A granted burst is locked until its last word, and a one-entry output
// register decouples the FIFO full flag from requester timing.
//   clk  : system clock
//   rst  : asynchronous, active-high reset (drops any pending output word)
//   bus  : sl_fifo_wr_arbiter_if.slave (requester offers, FIFO port, status)
// Optional build macro SL_ARB_TIMEOUT_EN: releases a lock after TIMEOUT
// consecutive cycles without an owner word and pulses timeout_err.
module sl_fifo_wr_arbiter
   import sl_fifo_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int WORD_W  = sl_fifo_pkg::WORD_W,
   parameter int TIMEOUT = 16
) (
   input logic                 clk,
   input logic                 rst,
   sl_fifo_wr_arbiter_if.slave bus
);

   localparam int               GID_W   = $clog2(N_REQ);
   localparam logic [GID_W-1:0] LAST_ID = GID_W'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("sl_fifo_wr_arbiter: N_REQ must be 2..8");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("sl_fifo_wr_arbiter: TIMEOUT must be at least 2");
   end

   arb_state_e        state_q;
   logic [GID_W-1:0]  owner_q;
   logic [GID_W-1:0]  rr_q;
   logic [GID_W-1:0]  pick_idx;
   logic [GID_W-1:0]  next_rr;
   logic              pick_hit;
   logic              slot_free;
   logic              owner_vld;
   logic              accept;
   logic              accept_last;
   logic [N_REQ-1:0]  ready;
   logic [WORD_W-1:0] req_word [N_REQ];
   logic [WORD_W-1:0] owner_word;
   logic              vld_p1;
   logic [WORD_W-1:0] data_p1;

`ifdef SL_ARB_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] idle_cnt_q;
   logic             timeout_err_q;
`endif

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign req_word[g] = bus.req_data[g*WORD_W +: WORD_W];
   end

   sl_rr_pick #(
      .N_REQ (N_REQ),
      .GID_W (GID_W)
   ) u_pick (
      .req   (bus.req_valid),
      .start (rr_q),
      .idx   (pick_idx),
      .hit   (pick_hit)
   );

   // Stage p0: owner selection and accept decision
   assign owner_vld   = bus.req_valid[owner_q];
   assign owner_word  = req_word[owner_q];
   assign slot_free   = !vld_p1 || !bus.fifo_write_full;
   assign accept      = (state_q == ARB_LOCK) && owner_vld && slot_free;
   assign accept_last = accept && bus.req_last[owner_q];
   assign next_rr     = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

   always_comb begin
      ready = '0;
      ready[owner_q] = accept;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ARB_IDLE;
         owner_q       <= '0;
         rr_q          <= '0;
`ifdef SL_ARB_TIMEOUT_EN
         idle_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
`ifdef SL_ARB_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            ARB_IDLE: begin
`ifdef SL_ARB_TIMEOUT_EN
               idle_cnt_q <= '0;
`endif
               // Grant only; the first word is taken in the following cycle.
               if (pick_hit) begin
                  owner_q <= pick_idx;
                  state_q <= ARB_LOCK;
               end
            end
            ARB_LOCK: begin
               if (accept_last) begin
                  state_q <= ARB_IDLE;
                  rr_q    <= next_rr;
               end
`ifdef SL_ARB_TIMEOUT_EN
               if (accept) begin
                  idle_cnt_q <= '0;
               end else if (!owner_vld) begin
                  if (idle_cnt_q == CNT_MAX) begin
                     state_q       <= ARB_IDLE;
                     rr_q          <= next_rr;
                     timeout_err_q <= 1'b1;
                     idle_cnt_q    <= '0;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + 1'b1;
                  end
               end
`endif
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   // Stage p1: one-entry output register toward the FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         data_p1 <= owner_word;
      end else if (!bus.fifo_write_full) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.req_ready       = ready;
   assign bus.fifo_write_data = data_p1;
   assign bus.fifo_write_inc  = vld_p1 && !bus.fifo_write_full;
   assign bus.grant_id        = owner_q;
   assign bus.busy            = (state_q == ARB_LOCK);
`ifdef SL_ARB_TIMEOUT_EN
   assign bus.timeout_err     = timeout_err_q;
`else
   assign bus.timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sl_fifo_wr_arbiter.sv
// Testbench for sl_fifo_wr_arbiter: requester queues feed the DUT, expected
// FIFO words are queued in arbitration order and compared on each push.
module tb_sl_fifo_wr_arbiter;
   import sl_fifo_pkg::*;

   localparam int N  = 4;
   localparam int W  = 34;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;

   sl_fifo_wr_arbiter_if #(.N_REQ(N), .WORD_W(W)) bus ();

   sl_fifo_wr_arbiter #(.N_REQ(N), .WORD_W(W), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           id;
      logic [W-1:0] data;
      logic         last;
   } ent_t;

   ent_t         sq[$];
   logic [W-1:0] sb[$];
   int           inc_cyc[$];
   int           terr_cyc[$];
   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   int           n_inc = 0;
   logic [N-1:0] rdy_snap = '0;

   function automatic logic [W-1:0] mk(input int id, input int n);
      fifo_word_t w;
      w.tag     = fifo_tag_e'(2'(n));
      w.payload = (32'(id) << 16) | 32'(n);
      return w;
   endfunction

   task automatic pop_first(input int id);
      for (int k = 0; k < sq.size(); k++) begin
         if (sq[k].id == id) begin
            sq.delete(k);
            break;
         end
      end
   endtask

   task automatic purge(input int id);
      for (int k = sq.size() - 1; k >= 0; k--) begin
         if (sq[k].id == id) sq.delete(k);
      end
   endtask

   task automatic drive_heads();
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic [W-1:0] d [N];
      v = '0;
      l = '0;
      for (int i = 0; i < N; i++) begin
         d[i] = '0;
         for (int k = 0; k < sq.size(); k++) begin
            if (sq[k].id == i) begin
               v[i] = 1'b1;
               l[i] = sq[k].last;
               d[i] = sq[k].data;
               break;
            end
         end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = {d[3], d[2], d[1], d[0]};
   endtask

   task automatic push_req(input int id, input logic [W-1:0] data, input logic last);
      ent_t e;
      e.id   = id;
      e.data = data;
      e.last = last;
      sq.push_back(e);
   endtask

   // Requester driver and FIFO-side monitor, one step per falling edge.
   initial begin
      logic [W-1:0] exp_w;
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (rdy_snap[i]) pop_first(i);
         end
         drive_heads();
         #1;
         rdy_snap = bus.req_ready;
         #1;
         if (bus.timeout_err === 1'b1) terr_cyc.push_back(cyc);
         if (bus.fifo_write_inc === 1'b1) begin
            n_inc++;
            inc_cyc.push_back(cyc);
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_underflow: pushed %h while no word was expected", bus.fifo_write_data);
            end else begin
               exp_w = sb.pop_front();
               if (bus.fifo_write_data !== exp_w) begin
                  bad++;
                  $display("FAIL word_order: got %h want %h", bus.fifo_write_data, exp_w);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic wait_drain(input int budget, output bit ok);
      int n = 0;
      while ((sb.size() != 0 || sq.size() != 0) && n < budget) begin
         @(negedge clk);
         #3;
         n++;
      end
      ok = (sb.size() == 0 && sq.size() == 0);
   endtask

   task automatic wait_inc(input int target, input int budget, output bit ok);
      int n = 0;
      while (n_inc < target && n < budget) begin
         @(negedge clk);
         #3;
         n++;
      end
      ok = (n_inc >= target);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sq.delete();
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #3;
      total++; if (bus.fifo_write_data !== '0)   begin bad++; $display("FAIL rst_data: got %h want 0", bus.fifo_write_data); end
      total++; if (bus.fifo_write_inc !== 1'b0)  begin bad++; $display("FAIL rst_inc: got %b want 0", bus.fifo_write_inc); end
      total++; if (bus.req_ready !== '0)         begin bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
      total++; if (bus.grant_id !== '0)          begin bad++; $display("FAIL rst_grant: got %0d want 0", bus.grant_id); end
      total++; if (bus.busy !== 1'b0)            begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      total++; if (bus.timeout_err !== 1'b0)     begin bad++; $display("FAIL rst_terr: got %b want 0", bus.timeout_err); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_burst();
      fifo_word_t w;
      int  base;
      bit  ok;
      base = inc_cyc.size();
      w.tag = TAG_DATA;   w.payload = 32'd456791; push_req(0, w, 1'b0);
      w.tag = TAG_STATUS; w.payload = 32'd76;     push_req(0, w, 1'b1);
      sb.push_back(34'h1_0006F857);
      sb.push_back(34'h2_0000004C);
      wait_drain(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_drain: %0d words outstanding, want 0", sb.size()); end
      total++;
      if (inc_cyc.size() - base != 2) begin
         bad++; $display("FAIL single_count: got %0d pushes want 2", inc_cyc.size() - base);
      end else if (inc_cyc[base+1] - inc_cyc[base] != 1) begin
         bad++; $display("FAIL single_gap: got %0d cycles between pushes want 1", inc_cyc[base+1] - inc_cyc[base]);
      end
      total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL single_busy: got %b want 0", bus.busy); end
      total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL single_grant: got %0d want 0", bus.grant_id); end
   endtask

   task automatic test_contention();
      bit ok;
      do_reset();
      for (int n = 0; n < 3; n++) push_req(0, mk(0, n), n == 2);
      for (int n = 0; n < 3; n++) push_req(2, mk(2, n), n == 2);
      for (int n = 0; n < 3; n++) sb.push_back(mk(0, n));
      for (int n = 0; n < 3; n++) sb.push_back(mk(2, n));
      wait_drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL cont_drain: %0d words outstanding, want 0", sb.size()); end
      total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL cont_grant: got %0d want 2", bus.grant_id); end
      // With the pointer at 3, requester 3 must win over requester 1.
      push_req(1, mk(1, 7), 1'b1);
      push_req(3, mk(3, 7), 1'b1);
      sb.push_back(mk(3, 7));
      sb.push_back(mk(1, 7));
      wait_drain(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL cont_rr_drain: %0d words outstanding, want 0", sb.size()); end
      total++; if (bus.grant_id !== 2'd1) begin bad++; $display("FAIL cont_rr_grant: got %0d want 1", bus.grant_id); end
   endtask

   task automatic test_fifo_full();
      bit ok;
      int base;
      base = n_inc;
      for (int n = 0; n < 6; n++) begin
         push_req(1, mk(1, 20 + n), n == 5);
         sb.push_back(mk(1, 20 + n));
      end
      wait_inc(base + 2, 50, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_start: got %0d pushes want 2", n_inc - base); end
      @(negedge clk);
      bus.fifo_write_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #3;
         total++; if (bus.fifo_write_inc !== 1'b0) begin bad++; $display("FAIL full_inc: got %b want 0", bus.fifo_write_inc); end
         total++; if (bus.req_ready !== '0)        begin bad++; $display("FAIL full_ready: got %b want 0", bus.req_ready); end
         total++; if (bus.busy !== 1'b1)           begin bad++; $display("FAIL full_busy: got %b want 1", bus.busy); end
         total++;
         if (sb.size() == 0 || bus.fifo_write_data !== sb[0]) begin
            bad++; $display("FAIL full_hold: got %h want head of %0d expected words", bus.fifo_write_data, sb.size());
         end
         @(negedge clk);
      end
      bus.fifo_write_full = 1'b0;
      wait_drain(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_drain: %0d words outstanding, want 0", sb.size()); end
   endtask

   task automatic test_fairness();
      bit ok;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int id = 0; id < N; id++) begin
            push_req(id, mk(id, 40 + r), 1'b1);
            sb.push_back(mk(id, 40 + r));
         end
      end
      wait_drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL fair_drain: %0d words outstanding, want 0", sb.size()); end
      total++; if (bus.grant_id !== 2'd3) begin bad++; $display("FAIL fair_grant: got %0d want 3", bus.grant_id); end
   endtask

   task automatic test_owner_stall();
      bit ok;
      int base;
      base = n_inc;
      push_req(0, mk(0, 60), 1'b0);
      push_req(1, mk(1, 60), 1'b1);
      sb.push_back(mk(0, 60));
      sb.push_back(mk(0, 61));
      sb.push_back(mk(1, 60));
      wait_inc(base + 1, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL stall_start: got %0d pushes want 1", n_inc - base); end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #3;
         total++; if (bus.busy !== 1'b1)        begin bad++; $display("FAIL stall_busy: got %b want 1", bus.busy); end
         total++; if (bus.grant_id !== 2'd0)    begin bad++; $display("FAIL stall_grant: got %0d want 0", bus.grant_id); end
         total++; if (bus.req_ready !== '0)     begin bad++; $display("FAIL stall_ready: got %b want 0", bus.req_ready); end
         total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL stall_terr: got %b want 0", bus.timeout_err); end
      end
      push_req(0, mk(0, 61), 1'b1);
      wait_drain(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL stall_drain: %0d words outstanding, want 0", sb.size()); end
      total++; if (bus.grant_id !== 2'd1) begin bad++; $display("FAIL stall_next: got %0d want 1", bus.grant_id); end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      int base;
      base = n_inc;
      for (int n = 0; n < 3; n++) begin
         push_req(2, mk(2, 80 + n), n == 2);
         sb.push_back(mk(2, 80 + n));
      end
      wait_inc(base + 1, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL rmid_start: got %0d pushes want 1", n_inc - base); end
      @(negedge clk);
      rst = 1'b1;
      purge(2);
      sb.delete();
      #1;
      total++; if (bus.fifo_write_data !== '0)  begin bad++; $display("FAIL rmid_data: got %h want 0", bus.fifo_write_data); end
      total++; if (bus.fifo_write_inc !== 1'b0) begin bad++; $display("FAIL rmid_inc: got %b want 0", bus.fifo_write_inc); end
      total++; if (bus.busy !== 1'b0)           begin bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
      total++; if (bus.grant_id !== 2'd0)       begin bad++; $display("FAIL rmid_grant: got %0d want 0", bus.grant_id); end
      push_req(2, mk(2, 90), 1'b1);
      sb.push_back(mk(2, 90));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #3;
         total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL rmid_hold_busy: got %b want 0", bus.busy); end
         total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL rmid_hold_ready: got %b want 0", bus.req_ready); end
      end
      @(negedge clk);
      rst = 1'b0;
      wait_drain(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL rmid_drain: %0d words outstanding, want 0", sb.size()); end
      total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL rmid_regrant: got %0d want 2", bus.grant_id); end
   endtask

`ifdef SL_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int bi;
      int bt;
      do_reset();
      bi = inc_cyc.size();
      bt = terr_cyc.size();
      push_req(0, mk(0, 100), 1'b0);
      push_req(1, mk(1, 100), 1'b1);
      sb.push_back(mk(0, 100));
      sb.push_back(mk(1, 100));
      wait_drain(80, ok);
      total++; if (!ok) begin bad++; $display("FAIL to_drain: %0d words outstanding, want 0", sb.size()); end
      total++;
      if (terr_cyc.size() - bt != 1 || inc_cyc.size() - bi != 2) begin
         bad++; $display("FAIL to_pulses: got %0d pulses %0d pushes want 1 and 2", terr_cyc.size() - bt, inc_cyc.size() - bi);
      end else begin
         total++;
         if (terr_cyc[bt] - inc_cyc[bi] != TO) begin
            bad++; $display("FAIL to_delay: got %0d cycles want %0d", terr_cyc[bt] - inc_cyc[bi], TO);
         end
         total++;
         if (inc_cyc[bi+1] - terr_cyc[bt] != 2) begin
            bad++; $display("FAIL to_next: got %0d cycles want 2", inc_cyc[bi+1] - terr_cyc[bt]);
         end
      end
      total++; if (bus.grant_id !== 2'd1) begin bad++; $display("FAIL to_grant: got %0d want 1", bus.grant_id); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.fifo_write_full = 1'b0;
      test_reset();
      test_single_burst();
      test_contention();
      test_fifo_full();
      test_fairness();
      test_owner_stall();
      test_reset_mid_burst();
`ifdef SL_ARB_TIMEOUT_EN
      test_timeout();
`endif
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sl_fifo_wr_arbiter.md
Name: sl_fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing one 34-bit outgoing FIFO write port between N_REQ bridge/channel requesters (RX data/status, config readback, TX status sources).
- Each word is {2-bit tag, 32-bit payload}.
- Requesters send bursts (e.g. RX data then RX status); a granted burst is never interleaved.
- A one-entry registered output stage isolates the FIFO full flag from requester timing.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_W, 34, FIFO word width (tag + payload).
- TIMEOUT, 16, idle cycles inside a burst before forced release (only with SL_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a word.
- req_data  in  N_REQ*WORD_W  word of requester i, slice i.
- req_last  in  N_REQ  word of requester i ends its burst.
- req_ready  out  N_REQ  word of requester i accepted this cycle (combinational).
- fifo_write_full  in  1  FIFO cannot accept.
- fifo_write_data  out  WORD_W  registered word to FIFO.
- fifo_write_inc  out  1  push strobe (combinational: out_vld && !fifo_write_full).
- grant_id  out  $clog2(N_REQ)  current/last owner.
- busy  out  1  burst lock held.
- timeout_err  out  1  one-cycle pulse on forced release (SL_ARB_TIMEOUT_EN only, else tied 0).

Behaviour:
- Reset values:
  - state IDLE, out_vld 0, fifo_write_data 0, fifo_write_inc 0.
  - req_ready 0, grant_id 0, busy 0, rr pointer 0, timeout counter 0, timeout_err 0.
- Output stage:
  - slot_free = !out_vld || !fifo_write_full.
  - A word loads into the output register when accepted.
  - out_vld clears when the slot drains and nothing loads.
- State IDLE:
  - Search req_valid starting at rr pointer, wrapping modulo N_REQ; pick the first set bit.
  - On a hit: owner <= i, grant_id <= i, go to LOCK. No word is accepted in the IDLE cycle, so arbitration latency is 1 cycle.
- State LOCK:
  - req_ready[owner] = req_valid[owner] && slot_free; all other bits are 0.
  - On accept with req_last: go to IDLE, rr pointer <= owner+1 (wrap to 0 after N_REQ-1).
- busy = (state == LOCK).
- Throughput: 1 word/cycle while the FIFO is not full. Word latency from accept to fifo_write_inc is 1 cycle.
- Full FIFO: the output register holds its data stable and req_ready stays 0. No word is lost or duplicated.
- Owner valid low mid-burst: stay in LOCK. Other requesters are blocked until the owner sends its last word (or timeout fires).
- Simultaneous requests: rotate fairly. Any persistently requesting source is granted within N_REQ bursts.
- rst mid-burst: all state clears immediately, including any pending output word (that word is dropped). The requester must resend the burst.

Optional Feature:
- SL_ARB_TIMEOUT_EN defined:
  - In LOCK, the counter increments each cycle the owner's req_valid is 0 and clears on any owner word.
  - When it reaches TIMEOUT-1: go to IDLE, advance rr pointer, pulse timeout_err.
- Not defined: no counter is implemented, timeout_err is 0, and the lock waits indefinitely for req_last.

Decomposition:
- Package sl_fifo_pkg holds:
  - WORD_W.
  - Tag enum: TAG_CONFIG=0, TAG_DATA=1, TAG_STATUS=2, TAG_CHANNEL=3.
  - Typedef fifo_word_t (tag[1:0], payload[31:0]).
  - Arbiter state enum {ARB_IDLE, ARB_LOCK}.
- One natural sub-module: sl_rr_pick, a combinational rotating priority encoder (req vector, start pointer -> index, hit).

Test Plan:
- Single burst: req0 sends {1,456791} then {2,76} with last on the second word, FIFO not full -> fifo_write_inc on two consecutive cycles, data 0x1_0006F857 then 0x2_0000004C, busy drops after the last word.
- Contention: req0 and req2 raise 3-word bursts in the same cycle, rr=0 -> all req0 words, then all req2 words with no interleave; rr pointer ends at 3.
- FIFO full: hold fifo_write_full high for 5 cycles during a burst -> fifo_write_data stable, no inc, req_ready 0; burst resumes on release with no word lost or duplicated.
- Fairness: all 4 requesters continuously send 1-word bursts -> grant order 0,1,2,3,0,1…
- Reset mid-burst: assert rst after word 1 of 3 -> outputs return to reset values the same cycle; a new grant occurs only after rst deasserts.
- With SL_ARB_TIMEOUT_EN and TIMEOUT=16: owner stalls after word 1 -> timeout_err pulses after 16 idle cycles and the next requester is granted.
